// File: rtl/cpu_pkg.sv
// Shared widths and immediate-extender encodings for the register file slice.
package cpu_pkg;

  localparam int CPU_DATA_W = 16;
  localparam int CPU_ADDR_W = 3;

  // ExtOp encodings
  localparam logic EXT_ZERO   = 1'b0;
  localparam logic EXT_SIGN   = 1'b1;

  // ExtPlace encodings
  localparam logic EXT_FIELD5 = 1'b0;
  localparam logic EXT_FIELD8 = 1'b1;

endpackage

// File: rtl/register_file_if.sv
// Bus bundle for register_file: read/write ports, immediate extender and comparator.
// The slave modport is the register_file side; master is the driving datapath.
interface register_file_if #(
  parameter int DATA_W = cpu_pkg::CPU_DATA_W,
  parameter int ADDR_W = cpu_pkg::CPU_ADDR_W
);

  logic [ADDR_W-1:0] RA;
  logic [ADDR_W-1:0] RB;
  logic [ADDR_W-1:0] RW;
  logic              enableWrite;
  logic [DATA_W-1:0] BusW;
  logic [DATA_W-1:0] BusA;
  logic [DATA_W-1:0] BusB;

  logic [7:0]        ExtIn;
  logic              ExtOp;
  logic              ExtPlace;
  logic [DATA_W-1:0] ExtOut;

  logic [DATA_W-1:0] CmpA;
  logic [DATA_W-1:0] CmpB;
  logic              gt;
  logic              lt;
  logic              eq;

  modport master (
    output RA, RB, RW, enableWrite, BusW,
    output ExtIn, ExtOp, ExtPlace,
    output CmpA, CmpB,
    input  BusA, BusB, ExtOut, gt, lt, eq
  );

  modport slave (
    input  RA, RB, RW, enableWrite, BusW,
    input  ExtIn, ExtOp, ExtPlace,
    input  CmpA, CmpB,
    output BusA, BusB, ExtOut, gt, lt, eq
  );

endinterface

// File: rtl/register_file_extender.sv
// Immediate extender: zero/sign extends a 5- or 8-bit field to DATA_W.
// Purely combinational, no handshake.
module extender
  import cpu_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W
) (
  input  logic [7:0]        ext_in_i,
  input  logic              ext_op_i,
  input  logic              ext_place_i,
  output logic [DATA_W-1:0] ext_out_o
);

  logic fill;

  always_comb begin
    fill = 1'b0;
    if (ext_op_i == EXT_SIGN) begin
      fill = (ext_place_i == EXT_FIELD8) ? ext_in_i[7] : ext_in_i[4];
    end
  end

  always_comb begin
    if (ext_place_i == EXT_FIELD8) begin
      ext_out_o = {{(DATA_W-8){fill}}, ext_in_i};
    end else begin
      ext_out_o = {{(DATA_W-5){fill}}, ext_in_i[4:0]};
    end
  end

endmodule

// File: rtl/register_file.sv
// 8-entry register file (R0 hardwired to zero) with immediate extender and signed comparator.
// Reads, extend and compare are zero-latency combinational; writes land on the next clk edge.
module register_file
  import cpu_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int ADDR_W = CPU_ADDR_W
) (
  input  logic            clk,
  input  logic            reset,
  register_file_if.slave  bus
);

  localparam int NREGS = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];

  always_comb begin
    regs_d = regs_q;
    if (bus.enableWrite && (bus.RW != '0)) begin
      regs_d[bus.RW] = bus.BusW;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // No write bypass: same-cycle forwarding lives in the surrounding datapath.
  assign bus.BusA = (bus.RA == '0) ? '0 : regs_q[bus.RA];
  assign bus.BusB = (bus.RB == '0) ? '0 : regs_q[bus.RB];

  extender #(
    .DATA_W (DATA_W)
  ) u_extender (
    .ext_in_i    (bus.ExtIn),
    .ext_op_i    (bus.ExtOp),
    .ext_place_i (bus.ExtPlace),
    .ext_out_o   (bus.ExtOut)
  );

  logic signed [DATA_W-1:0] cmp_a_s;
  logic signed [DATA_W-1:0] cmp_b_s;

  assign cmp_a_s = bus.CmpA;
  assign cmp_b_s = bus.CmpB;

  // eq derived from the other two so exactly one flag is always set.
  assign bus.gt = (cmp_a_s > cmp_b_s);
  assign bus.lt = (cmp_a_s < cmp_b_s);
  assign bus.eq = !bus.gt && !bus.lt;

endmodule

// File: tb/tb_register_file.sv
// Directed and model-based bench for register_file.
module tb_register_file;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  register_file_if #(.DATA_W(16), .ADDR_W(3)) bus ();

  register_file #(.DATA_W(16), .ADDR_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.RA = 3'd0; bus.RB = 3'd0; bus.RW = 3'd0;
    bus.enableWrite = 1'b0; bus.BusW = 16'h0000;
    bus.ExtIn = 8'h00; bus.ExtOp = 1'b0; bus.ExtPlace = 1'b0;
    bus.CmpA = 16'h0000; bus.CmpB = 16'h0000;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.RA = 3'(i);
      bus.RB = 3'(7 - i);
      #1;
      checks++;
      if (bus.BusA !== 16'h0000) begin
        errors++;
        $display("FAIL reset_busa idx=%0d got=%h exp=0000", i, bus.BusA);
      end
      checks++;
      if (bus.BusB !== 16'h0000) begin
        errors++;
        $display("FAIL reset_busb idx=%0d got=%h exp=0000", 7 - i, bus.BusB);
      end
    end
  endtask

  task automatic test_write();
    bus.RW = 3'd3; bus.BusW = 16'hBEEF; bus.enableWrite = 1'b1;
    bus.RA = 3'd3; bus.RB = 3'd3;
    #1;
    checks++;
    if (bus.BusA !== 16'h0000) begin
      errors++;
      $display("FAIL write_cycle_old got=%h exp=0000", bus.BusA);
    end
    tick();
    bus.enableWrite = 1'b0;
    #1;
    checks++;
    if (bus.BusA !== 16'hBEEF) begin
      errors++;
      $display("FAIL write_r3_busa got=%h exp=beef", bus.BusA);
    end
    checks++;
    if (bus.BusB !== 16'hBEEF) begin
      errors++;
      $display("FAIL write_r3_same_index_busb got=%h exp=beef", bus.BusB);
    end
    bus.BusW = 16'h1111;
    tick();
    checks++;
    if (bus.BusA !== 16'hBEEF) begin
      errors++;
      $display("FAIL write_disabled got=%h exp=beef", bus.BusA);
    end
    bus.RW = 3'd7; bus.BusW = 16'h00A5; bus.enableWrite = 1'b1;
    tick();
    bus.enableWrite = 1'b0; bus.RA = 3'd7; bus.RB = 3'd3;
    #1;
    checks++;
    if (bus.BusA !== 16'h00A5 || bus.BusB !== 16'hBEEF) begin
      errors++;
      $display("FAIL write_r7 busa=%h busb=%h exp=00a5/beef", bus.BusA, bus.BusB);
    end
  endtask

  task automatic test_r0_and_reset_priority();
    bus.RW = 3'd0; bus.BusW = 16'h1234; bus.enableWrite = 1'b1;
    tick();
    bus.enableWrite = 1'b0; bus.RA = 3'd0; bus.RB = 3'd0;
    #1;
    checks++;
    if (bus.BusA !== 16'h0000 || bus.BusB !== 16'h0000) begin
      errors++;
      $display("FAIL r0_write busa=%h busb=%h exp=0000", bus.BusA, bus.BusB);
    end
    bus.RW = 3'd5; bus.BusW = 16'h5555; bus.enableWrite = 1'b1;
    tick();
    bus.RA = 3'd5;
    #1;
    checks++;
    if (bus.BusA !== 16'h5555) begin
      errors++;
      $display("FAIL r5_pre got=%h exp=5555", bus.BusA);
    end
    reset = 1'b1; bus.BusW = 16'hAAAA;
    tick();
    reset = 1'b0; bus.enableWrite = 1'b0; bus.RB = 3'd3;
    #1;
    checks++;
    if (bus.BusA !== 16'h0000) begin
      errors++;
      $display("FAIL reset_priority_r5 got=%h exp=0000", bus.BusA);
    end
    checks++;
    if (bus.BusB !== 16'h0000) begin
      errors++;
      $display("FAIL reset_clears_r3 got=%h exp=0000", bus.BusB);
    end
    bus.BusW = 16'h0ABC; bus.enableWrite = 1'b1;
    tick();
    bus.enableWrite = 1'b0;
    #1;
    checks++;
    if (bus.BusA !== 16'h0ABC) begin
      errors++;
      $display("FAIL resume_after_reset got=%h exp=0abc", bus.BusA);
    end
  endtask

  task automatic test_extender();
    logic [7:0]  ins  [6] = '{8'h9F, 8'h9F, 8'h9F, 8'h9F, 8'h6F, 8'h10};
    logic        ops  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic        plcs [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [15:0] exps [6] = '{16'hFF9F, 16'h009F, 16'hFFFF, 16'h001F, 16'h006F, 16'hFFF0};
    for (int i = 0; i < 6; i++) begin
      bus.ExtIn = ins[i]; bus.ExtOp = ops[i]; bus.ExtPlace = plcs[i];
      #1;
      checks++;
      if (bus.ExtOut !== exps[i]) begin
        errors++;
        $display("FAIL extender case=%0d in=%h op=%b place=%b got=%h exp=%h",
                 i, ins[i], ops[i], plcs[i], bus.ExtOut, exps[i]);
      end
    end
  endtask

  task automatic test_compare();
    logic [15:0] as_ [6] = '{16'hFFFF, 16'h7FFF, 16'h0042, 16'h8000, 16'h0000, 16'h8000};
    logic [15:0] bs_ [6] = '{16'h0001, 16'h8000, 16'h0042, 16'h7FFF, 16'hFFFF, 16'h8000};
    logic [2:0]  exp [6] = '{3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001};
    logic [2:0]  got;
    for (int i = 0; i < 6; i++) begin
      bus.CmpA = as_[i]; bus.CmpB = bs_[i];
      #1;
      got = {bus.gt, bus.lt, bus.eq};
      checks++;
      if (got !== exp[i]) begin
        errors++;
        $display("FAIL compare case=%0d a=%h b=%h gt_lt_eq=%b exp=%b", i, as_[i], bs_[i], got, exp[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] model [8];
    logic [31:0] r;
    logic [2:0]  flags;
    logic [2:0]  exp_flags;
    int          sa;
    int          sb;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) model[i] = 16'h0000;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      r = $urandom;
      bus.RA = r[2:0]; bus.RB = r[5:3]; bus.RW = r[8:6];
      bus.enableWrite = r[9];
      reset = (r[15:10] == 6'd0);
      r = $urandom;
      bus.BusW = r[15:0];
      bus.CmpA = {r[31:28], r[27:16] & {12{r[16]}}};
      r = $urandom;
      bus.CmpB = (r[31:30] == 2'b00) ? bus.CmpA : r[15:0];
      #1;
      checks++;
      if (bus.BusA !== model[bus.RA] || bus.BusB !== model[bus.RB]) begin
        errors++;
        $display("FAIL random_read cyc=%0d ra=%0d rb=%0d busa=%h busb=%h exp=%h/%h",
                 cyc, bus.RA, bus.RB, bus.BusA, bus.BusB, model[bus.RA], model[bus.RB]);
      end
      sa = int'($signed(bus.CmpA));
      sb = int'($signed(bus.CmpB));
      exp_flags = (sa > sb) ? 3'b100 : (sa < sb) ? 3'b010 : 3'b001;
      flags = {bus.gt, bus.lt, bus.eq};
      checks++;
      if (flags !== exp_flags) begin
        errors++;
        $display("FAIL random_compare cyc=%0d a=%h b=%h gt_lt_eq=%b exp=%b",
                 cyc, bus.CmpA, bus.CmpB, flags, exp_flags);
      end
      tick();
      if (reset) begin
        for (int i = 0; i < 8; i++) model[i] = 16'h0000;
      end else if (bus.enableWrite && bus.RW != 3'd0) begin
        model[bus.RW] = bus.BusW;
      end
    end
    reset = 1'b0;
    bus.enableWrite = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    idle_inputs();
    test_reset();
    test_write();
    test_r0_and_reset_priority();
    test_extender();
    test_compare();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set the register, bus, immediate and compare width.
REQ-002 Parameter ADDR_W, default 3, SHALL give 2**ADDR_W = 8 architectural registers R0..R7.
REQ-003 The block SHALL have one clock; reset SHALL be synchronous and active-high.
REQ-004 clk  in  1  clock; all state updates occur on the rising edge.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 RA  in  ADDR_W  read-port A register index.
REQ-007 RB  in  ADDR_W  read-port B register index.
REQ-008 RW  in  ADDR_W  write register index.
REQ-009 enableWrite  in  1  write enable for the BusW/RW port.
REQ-010 BusW  in  DATA_W  write data.
REQ-011 BusA  out  DATA_W  contents of register RA.
REQ-012 BusB  out  DATA_W  contents of register RB.
REQ-013 ExtIn  in  8  raw immediate field (instruction bits [7:0]).
REQ-014 ExtOp  in  1  1 = sign-extend, 0 = zero-extend.
REQ-015 ExtPlace  in  1  1 = 8-bit field ExtIn[7:0], 0 = 5-bit field ExtIn[4:0].
REQ-016 ExtOut  out  DATA_W  extended immediate.
REQ-017 CmpA  in  DATA_W  compare operand A (the forwarded value A).
REQ-018 CmpB  in  DATA_W  compare operand B (the forwarded value B).
REQ-019 gt, lt, eq  out  1 each  compare flags.

Function
REQ-020 Register write: on a rising clk edge with reset=0, enableWrite=1 and RW!=0, register[RW] SHALL take BusW.
REQ-021 R0 SHALL always read 0; writes to R0 SHALL be ignored.
REQ-022 Reads SHALL be combinational: BusA=register[RA] and BusB=register[RB], with zero cycles of latency.
REQ-023 There SHALL be no internal write-to-read bypass: a read of RW in the write cycle returns the old value until the clock edge. Same-cycle forwarding is done outside this block.
REQ-024 RA=RB SHALL be legal, and both buses SHALL then show the same value.
REQ-025 Extender (combinational), ExtPlace=1: ExtOut = {ExtOp ? ExtIn[7] replicated : 0, ExtIn[7:0]}, filling the upper DATA_W-8 bits.
REQ-026 Extender (combinational), ExtPlace=0: ExtOut = {ExtOp ? ExtIn[4] replicated : 0, ExtIn[4:0]}, filling the upper DATA_W-5 bits.
REQ-027 Compare (combinational) SHALL treat CmpA and CmpB as signed two's complement.
REQ-028 Compare flags: eq=1 iff CmpA==CmpB; gt=1 iff CmpA>CmpB; lt=1 iff CmpA<CmpB.
REQ-029 Exactly one of gt, lt and eq SHALL be 1 for every input, with no X on outputs when inputs are known.
REQ-030 The extender and compare outputs SHALL be independent of clk and reset.

Reset
REQ-031 While reset=1 at a rising edge, all registers SHALL clear to 0, and BusA and BusB SHALL read 0 after that edge.
REQ-032 Reset SHALL take priority over a simultaneous write; the write is discarded.
REQ-033 Deasserting reset mid-sequence SHALL resume normal writes on the next edge, with no further state.

Structure
REQ-034 DATA_W, ADDR_W and the ExtOp/ExtPlace encodings SHALL live in a shared package (cpu_pkg).
REQ-035 The immediate extender SHALL be a sub-module named extender, instantiated once.
REQ-036 The comparator SHALL be inline logic in register_file.
REQ-037 Storage SHALL be a single 8 x DATA_W array with two asynchronous read ports and one synchronous write port.

Verification
REQ-038 Reset, then read all 8 indices -> BusA=BusB=0x0000.
REQ-039 Write RW=3, BusW=0xBEEF, enableWrite=1 -> BusA (RA=3) reads 0xBEEF from the next cycle, old value in the write cycle; the same write with enableWrite=0 leaves R3 unchanged.
REQ-040 Write RW=0, BusW=0x1234 -> R0 still reads 0x0000; reset=1 together with a write to R5 -> R5=0x0000.
REQ-041 ExtIn=0x9F -> ExtOut values:
- ExtOp=1, ExtPlace=1 -> 0xFF9F.
- ExtOp=0, ExtPlace=1 -> 0x009F.
- ExtOp=1, ExtPlace=0 -> 0xFFFF.
- ExtOp=0, ExtPlace=0 -> 0x001F.
REQ-042 Compare cases -> flags:
- CmpA=0xFFFF, CmpB=0x0001 -> lt=1.
- CmpA=0x7FFF, CmpB=0x8000 -> gt=1.
- CmpA=CmpB=0x0042 -> eq=1 only.
REQ-043 Random writes/reads checked against a reference model for 10k cycles, with the one-hot flag property asserted every cycle.
